// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC-driven req/ack fetch into a prefetch queue,
// drained by decode over valid/ready, with flush for PC rewrites.
module fetch_unit #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcin,
  output logic        pcincr,
  input  logic        halt,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_out,
  output logic [31:0] ins_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     dat_q [DEPTH];
  logic [31:0]     adr_q [DEPTH];
  logic [PW-1:0]   wr_q, rd_q;
  logic [CNTW-1:0] cnt_q, cnt_n;
  logic            acc, pop;

  assign acc       = (state_q == REQ) & mem_ack & ~flush;
  assign pcincr    = acc;
  assign ins_valid = (cnt_q != '0);
  assign pop       = ins_valid & ins_ready & ~flush;
  assign mem_req   = (state_q != IDLE);
  assign mem_addr  = addr_q;
  assign ins_out   = dat_q[rd_q];
  assign ins_addr  = adr_q[rd_q];

  // pop implies cnt_q >= 1, so this never underflows
  assign cnt_n = cnt_q + {{(CNTW-1){1'b0}}, acc}
                       - {{(CNTW-1){1'b0}}, pop};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (~halt & ~flush & (cnt_q < FULL)) begin
          state_d = REQ;
          addr_d  = pcin;
        end
      end
      REQ: begin
        if (flush) begin
          state_d = mem_ack ? IDLE : DROP;
        end else if (mem_ack) begin
          if (~halt & (cnt_n < FULL)) begin
            addr_d = addr_q + 32'd1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= '0;
        adr_q[i] <= '0;
      end
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (acc) begin
        dat_q[wr_q] <= mem_rdata;
        adr_q[wr_q] <= addr_q;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + PW'(1);
      end
      cnt_q <= cnt_n;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level queue model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fetch_unit;

  localparam int DEPTH = 4;
  localparam logic [31:0] KEY = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pcin;
  logic        pcincr;
  logic        halt = 1'b0;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        ins_valid;
  logic        ins_ready = 1'b0;
  logic [31:0] ins_out;
  logic [31:0] ins_addr;

  int tests = 0;
  int fails = 0;
  int lat = 0;
  int wcnt = 0;
  int tally = 0;
  logic [31:0] pc = '0;
  logic [31:0] newpc = '0;

  bit          m_pend;
  bit          m_drop;
  logic [31:0] m_addr;
  logic [63:0] m_q[$];

  fetch_unit #(.DEPTH(DEPTH), .CNTW(3)) dut (
    .clk(clk), .rst(rst), .pcin(pcin), .pcincr(pcincr),
    .halt(halt), .flush(flush), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .ins_valid(ins_valid),
    .ins_ready(ins_ready), .ins_out(ins_out),
    .ins_addr(ins_addr)
  );

  always #5 clk = ~clk;

  assign pcin      = pc;
  assign mem_rdata = mem_addr ^ KEY;
  assign mem_ack   = mem_req && (wcnt >= lat);

  // memory: ack arrives after lat cycles of a held request
  always @(posedge clk) begin
    if (!mem_req || mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check();
    logic [31:0] ea;
    chk("mem_req", 32'(mem_req), 32'(m_pend));
    if (m_pend) chk("mem_addr", mem_addr, m_addr);
    chk("pcincr", 32'(pcincr),
        32'(m_pend && !m_drop && mem_ack && !flush));
    chk("ins_valid", 32'(ins_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      ea = m_q[0][63:32];
      chk("ins_addr", ins_addr, ea);
      ea = m_q[0][31:0];
      chk("ins_out", ins_out, ea);
    end
  endtask

  task automatic model_update();
    int  n0;
    bit  acc, pop;
    n0  = m_q.size();
    acc = m_pend && !m_drop && mem_ack && !flush;
    pop = (n0 != 0) && ins_ready && !flush;
    if (flush) begin
      m_q.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (acc) m_q.push_back({m_addr, m_addr ^ KEY});
    end
    if (!m_pend) begin
      if (!halt && !flush && n0 < DEPTH) begin
        m_pend = 1'b1;
        m_addr = pcin;
      end
    end else if (m_drop) begin
      if (mem_ack) begin
        m_pend = 1'b0;
        m_drop = 1'b0;
      end
    end else if (flush) begin
      if (mem_ack) m_pend = 1'b0;
      else m_drop = 1'b1;
    end else if (mem_ack) begin
      if (!halt && m_q.size() < DEPTH) m_addr = m_addr + 32'd1;
      else m_pend = 1'b0;
    end
  endtask

  // called at a negedge with inputs set; returns at the next negedge
  task automatic step();
    bit inc, fl;
    #1;
    check();
    model_update();
    inc = pcincr;
    fl  = flush;
    tally += int'(inc);
    @(negedge clk);
    if (fl) pc = newpc;
    else if (inc) pc = pc + 32'd1;
  endtask

  task automatic flush_to(logic [31:0] v);
    flush = 1'b1;
    newpc = v;
    step();
    flush = 1'b0;
  endtask

  task automatic settle();
    halt = 1'b1;
    ins_ready = 1'b1;
    lat = 0;
    repeat (8) step();
    halt = 1'b0;
  endtask

  initial begin
    m_pend = 1'b0;
    m_drop = 1'b0;
    m_addr = '0;
    m_q.delete();
    pc = 32'h10;
    ins_ready = 1'b1;
    #12;
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_incr", 32'(pcincr), 32'h0);
    chk("rst_valid", 32'(ins_valid), 32'h0);
    chk("rst_out", ins_out, 32'h0);
    chk("rst_iaddr", ins_addr, 32'h0);

    // streaming from 0x10
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("t1_req", 32'(mem_req), 32'h1);
    chk("t1_addr0", mem_addr, 32'h10);
    chk("t1_incr", 32'(pcincr), 32'h1);
    chk("t1_empty", 32'(ins_valid), 32'h0);
    step();
    chk("t1_addr1", mem_addr, 32'h11);
    chk("t1_head", ins_addr, 32'h10);
    chk("t1_data", ins_out, 32'h10 ^ KEY);
    repeat (6) step();
    chk("t1_addr7", mem_addr, 32'h17);
    chk("t1_head7", ins_addr, 32'h16);

    // decode stalled: queue fills with exactly DEPTH words
    ins_ready = 1'b0;
    flush_to(32'h40);
    tally = 0;
    repeat (8) step();
    chk("t2_pushes", 32'(tally), 32'd4);
    chk("t2_idle", 32'(mem_req), 32'h0);
    chk("t2_head", ins_addr, 32'h40);
    ins_ready = 1'b1;
    step();
    chk("t2_pop1", ins_addr, 32'h41);
    step();
    chk("t2_pop2", ins_addr, 32'h42);
    chk("t2_resume", mem_addr, 32'h44);
    chk("t2_rreq", 32'(mem_req), 32'h1);
    repeat (4) step();

    // 3-cycle ack delay
    settle();
    lat = 3;
    flush_to(32'h100);
    step();
    tally = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_req", 32'(mem_req), 32'h1);
      chk("t3_hold", mem_addr, 32'h100);
      step();
    end
    chk("t3_one_incr", 32'(tally), 32'd1);
    chk("t3_next", mem_addr, 32'h101);
    repeat (4) step();

    // flush with request outstanding -> DROP
    settle();
    lat = 2;
    flush_to(32'h70);
    step();
    chk("t4_addr", mem_addr, 32'h70);
    step();
    flush = 1'b1;
    newpc = 32'h80;
    step();
    flush = 1'b0;
    chk("t4_drop_req", 32'(mem_req), 32'h1);
    chk("t4_drop_addr", mem_addr, 32'h70);
    chk("t4_drop_incr", 32'(pcincr), 32'h0);
    chk("t4_empty", 32'(ins_valid), 32'h0);
    step();
    chk("t4_idle", 32'(mem_req), 32'h0);
    step();
    chk("t4_newreq", 32'(mem_req), 32'h1);
    chk("t4_newaddr", mem_addr, 32'h80);
    repeat (4) step();

    // flush coincident with ack and pop, two entries queued
    settle();
    ins_ready = 1'b0;
    flush_to(32'h200);
    step();
    step();
    step();
    chk("t5_valid", 32'(ins_valid), 32'h1);
    chk("t5_head", ins_addr, 32'h200);
    flush = 1'b1;
    ins_ready = 1'b1;
    newpc = 32'h300;
    step();
    flush = 1'b0;
    chk("t5_cleared", 32'(ins_valid), 32'h0);
    chk("t5_idle", 32'(mem_req), 32'h0);
    step();
    chk("t5_req", 32'(mem_req), 32'h1);
    chk("t5_addr", mem_addr, 32'h300);
    repeat (3) step();

    // halt with an ack pending
    settle();
    lat = 2;
    flush_to(32'h500);
    step();
    step();
    halt = 1'b1;
    tally = 0;
    repeat (5) step();
    chk("t6_one_push", 32'(tally), 32'd1);
    chk("t6_idle", 32'(mem_req), 32'h0);
    halt = 1'b0;

    // address wrap
    settle();
    flush_to(32'hFFFF_FFFE);
    step();
    chk("t7_a0", mem_addr, 32'hFFFF_FFFE);
    step();
    chk("t7_a1", mem_addr, 32'hFFFF_FFFF);
    step();
    chk("t7_wrap", mem_addr, 32'h0000_0000);
    chk("t7_head", ins_addr, 32'hFFFF_FFFF);

    // mixed traffic against the model
    for (int i = 0; i < 300; i++) begin
      ins_ready = ($urandom_range(0, 3) != 0);
      halt  = ($urandom_range(0, 7) == 0);
      lat   = $urandom_range(0, 2);
      flush = ($urandom_range(0, 15) == 0);
      newpc = $urandom;
      step();
    end
    flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
